// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the operand-usage decoder used by operand fetch.
package rv32i_pkg;
    localparam int REG_IDX_W = 5;
    localparam int RF_IDX_W  = 6;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef struct packed {
        logic                 uses_rs1;
        logic                 uses_rs2;
        logic                 writes_rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       csr_reg;
        opc     = instr[6:0];
        f3      = instr[14:12];
        // CSR ops with a register source (CSRRW/S/C); immediate forms have funct3[2]=1
        csr_reg = (opc == SYSTEM) && !f3[2] && (f3 != 3'd0);
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        d.rd    = instr[11:7];
        d.uses_rs1 = (opc == JALR) || (opc == BRANCH) || (opc == LOAD) || (opc == STORE) ||
                     (opc == OP_IMM) || (opc == OP) || csr_reg;
        d.uses_rs2 = (opc == BRANCH) || (opc == STORE) || (opc == OP);
        d.writes_rd = ((opc == LUI) || (opc == AUIPC) || (opc == JAL) || (opc == JALR) ||
                       (opc == LOAD) || (opc == OP_IMM) || (opc == OP) ||
                       ((opc == SYSTEM) && (f3 != 3'd0))) && (d.rd != '0);
        return d;
    endfunction
endpackage

// File: rtl/operand_scoreboard.sv
// Busy bits for x1..x31; a set in the same cycle as a clear of that index wins.
module operand_scoreboard
    import rv32i_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic                 fclr_en,
    input  logic [REG_IDX_W-1:0] fclr_idx,
    output logic [31:0]          busy
);
    logic [31:1] busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (set_en && set_idx == REG_IDX_W'(i))
                    busy_q[i] <= 1'b1;
                else if ((clr_en && clr_idx == REG_IDX_W'(i)) ||
                         (fclr_en && fclr_idx == REG_IDX_W'(i)))
                    busy_q[i] <= 1'b0;
            end
        end
    end

    assign busy = {busy_q, 1'b0};
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard hazard check, writeback bypass and a single
// registered output slot with backpressure and flush.
module operand_fetch
    import rv32i_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [31:0]            in_pc,
    output logic [RF_IDX_W-1:0]    rf_rs1,
    output logic [RF_IDX_W-1:0]    rf_rs2,
    input  logic [31:0]            rf_rd_rs1,
    input  logic [31:0]            rf_rd_rs2,
    input  logic                   wb_valid,
    input  logic                   wb_we,
    input  logic [RF_IDX_W-1:0]    wb_rd,
    input  logic [31:0]            wb_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_op1,
    output logic [31:0]            out_op2,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    dec_t                 dec;
    logic [31:0]          busy;
    logic                 wb_ok, byp1, byp2, hazard, capture;
    logic [31:0]          op1, op2;
    logic                 out_sets_rd;
    logic [REG_IDX_W-1:0] out_rd;

    always_comb dec = decode(in_instr);

    assign rf_rs1 = {1'b0, dec.rs1};
    assign rf_rs2 = {1'b0, dec.rs2};

    // Writebacks to x0 or the upper (non-integer) index space never touch state
    assign wb_ok = wb_valid && !wb_rd[5] && (wb_rd[4:0] != '0);
    assign byp1  = wb_ok && wb_we && (wb_rd[4:0] == dec.rs1);
    assign byp2  = wb_ok && wb_we && (wb_rd[4:0] == dec.rs2);

    assign op1 = !dec.uses_rs1 ? 32'd0 : (byp1 ? wb_data : rf_rd_rs1);
    assign op2 = !dec.uses_rs2 ? 32'd0 : (byp2 ? wb_data : rf_rd_rs2);

    assign hazard = (dec.uses_rs1 && busy[dec.rs1] && !byp1) ||
                    (dec.uses_rs2 && busy[dec.rs2] && !byp2) ||
                    (dec.writes_rd && busy[dec.rd] && !(wb_ok && wb_rd[4:0] == dec.rd));

    assign in_ready = !rst && !hazard && !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    operand_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (capture && dec.writes_rd),
        .set_idx  (dec.rd),
        .clr_en   (wb_ok),
        .clr_idx  (wb_rd[4:0]),
        .fclr_en  (flush && out_valid && out_sets_rd),
        .fclr_idx (out_rd),
        .busy     (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_sets_rd <= 1'b0;
            out_rd      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_instr   <= in_instr;
            out_pc      <= in_pc;
            out_op1     <= op1;
            out_op2     <= op2;
            out_sets_rd <= dec.writes_rd;
            out_rd      <= dec.rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (in_valid && !in_ready)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, throughput, RAW bypass, x0, backpressure/flush, set/clear collision.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [5:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rd_rs1, rf_rd_rs2;
    logic        wb_valid = 1'b0;
    logic        wb_we = 1'b0;
    logic [5:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr, out_pc, out_op1, out_op2;
    logic [31:0] stall_cnt;

    logic [31:0] rf_mem [64];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rf_rd_rs1 = rf_mem[rf_rs1];
    assign rf_rd_rs2 = rf_mem[rf_rs2];

    operand_fetch #(.STALL_CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rd_rs1(rf_rd_rs1), .rf_rd_rs2(rf_rd_rs2), .wb_valid(wb_valid),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .stall_cnt(stall_cnt)
    );

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; wb_valid = 0; wb_we = 0; flush = 0; out_ready = 1;
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; out_ready = 1;
        in_instr = enc_i(12'd3, 5'd0, 3'd0, 5'd1, 7'b0010011);
        for (int c = 0; c < 2; c++) begin
            step();
            tests++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
            tests++;
            if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
        end
        tests++;
        if (out_instr !== 32'd0 || out_op1 !== 32'd0 || dut.busy !== 32'd0) begin
            fails++; $display("FAIL reset_regs instr %h op1 %h busy %h exp 0", out_instr, out_op1, dut.busy);
        end
        in_valid = 0;
        rst = 0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] i1, i2;
        do_reset();
        i1 = enc_i(12'd3, 5'd0, 3'd0, 5'd1, 7'b0010011);
        i2 = enc_add(5'd3, 5'd2, 5'd4);
        in_valid = 1; in_instr = i1; in_pc = 32'h40;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1 got %b exp 1", in_ready); end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_instr !== i1 || out_pc !== 32'h40 || out_op1 !== 0 || out_op2 !== 0) begin
            fails++; $display("FAIL b2b_first v %b instr %h pc %h ops %h/%h exp 1 %h 40 0/0", out_valid, out_instr, out_pc, out_op1, out_op2, i1);
        end
        in_instr = i2; in_pc = 32'h44;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready2 got %b exp 1", in_ready); end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_instr !== i2 || out_op1 !== 32'd5 || out_op2 !== 32'd7) begin
            fails++; $display("FAIL b2b_second v %b instr %h ops %h/%h exp 1 %h 5/7", out_valid, out_instr, out_op1, out_op2, i2);
        end
        in_valid = 0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
        tests++;
        if (dut.busy !== 32'h0000_000A) begin fails++; $display("FAIL b2b_busy got %h exp 0000000a", dut.busy); end
    endtask

    task automatic test_raw_stall();
        logic [31:0] add_i;
        do_reset();
        add_i = enc_add(5'd6, 5'd5, 5'd5);
        in_valid = 1; in_instr = enc_i(12'd0, 5'd0, 3'd2, 5'd5, 7'b0000011); in_pc = 32'h100;
        step();
        in_instr = add_i; in_pc = 32'h104;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL raw_stall_ready c%0d got %b exp 0", c, in_ready); end
            step();
        end
        wb_valid = 1; wb_we = 1; wb_rd = 6'd5; wb_data = 32'h1234;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL raw_wb_ready got %b exp 1", in_ready); end
        step();
        wb_valid = 0; wb_we = 0; in_valid = 0;
        tests++;
        if (out_valid !== 1'b1 || out_instr !== add_i || out_op1 !== 32'h1234 || out_op2 !== 32'h1234) begin
            fails++; $display("FAIL raw_bypass v %b instr %h ops %h/%h exp 1 %h 1234/1234", out_valid, out_instr, out_op1, out_op2, add_i);
        end
        tests++;
        if (stall_cnt !== 32'd3) begin fails++; $display("FAIL raw_stall_cnt got %0d exp 3", stall_cnt); end
        tests++;
        if (dut.busy !== 32'h0000_0040) begin fails++; $display("FAIL raw_busy got %h exp 00000040", dut.busy); end
    endtask

    task automatic test_x0();
        do_reset();
        in_valid = 1; in_instr = enc_add(5'd0, 5'd0, 5'd0); in_pc = 32'h200;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL x0_ready1 got %b exp 1", in_ready); end
        step();
        tests++;
        if (out_op1 !== 0 || out_op2 !== 0 || dut.busy !== 0) begin
            fails++; $display("FAIL x0_first ops %h/%h busy %h exp 0/0 0", out_op1, out_op2, dut.busy);
        end
        // writeback aimed at x0 must not be forwarded
        in_instr = enc_add(5'd1, 5'd0, 5'd0);
        wb_valid = 1; wb_we = 1; wb_rd = 6'd0; wb_data = 32'h55;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL x0_ready2 got %b exp 1", in_ready); end
        step();
        wb_valid = 0; wb_we = 0;
        tests++;
        if (out_op1 !== 0 || out_op2 !== 0 || dut.busy !== 32'h2 || stall_cnt !== 0) begin
            fails++; $display("FAIL x0_second ops %h/%h busy %h stall %0d exp 0/0 2 0", out_op1, out_op2, dut.busy, stall_cnt);
        end
        // x1 busy; a writeback with index bit 5 set is not x1
        in_instr = enc_add(5'd2, 5'd1, 5'd0);
        wb_valid = 1; wb_we = 1; wb_rd = 6'h21; wb_data = 32'h99;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL x0_wbrd5 got %b exp 0", in_ready); end
        step();
        wb_valid = 0; wb_we = 0; in_valid = 0;
        tests++;
        if (dut.busy !== 32'h2) begin fails++; $display("FAIL x0_wbrd5_busy got %h exp 00000002", dut.busy); end
    endtask

    task automatic test_backpressure_flush();
        logic [31:0] i1, i2;
        do_reset();
        i1 = enc_i(12'h7ff, 5'd0, 3'd0, 5'd9, 7'b0010011);
        i2 = enc_add(5'd3, 5'd2, 5'd4);
        out_ready = 0; in_valid = 1; in_instr = i1; in_pc = 32'h300;
        step();
        in_instr = i2; in_pc = 32'h304;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready c%0d got %b exp 0", c, in_ready); end
            step();
            tests++;
            if (out_valid !== 1'b1 || out_instr !== i1 || out_pc !== 32'h300 || out_op1 !== 0) begin
                fails++; $display("FAIL bp_hold c%0d v %b instr %h pc %h op1 %h exp 1 %h 300 0", c, out_valid, out_instr, out_pc, out_op1, i1);
            end
        end
        tests++;
        if (dut.busy !== 32'h200) begin fails++; $display("FAIL bp_busy got %h exp 00000200", dut.busy); end
        flush = 1; out_ready = 1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %b exp 0", in_ready); end
        step();
        flush = 0;
        tests++;
        if (out_valid !== 1'b0 || dut.busy !== 32'd0 || stall_cnt !== 32'd4) begin
            fails++; $display("FAIL flush_result v %b busy %h stall %0d exp 0 0 4", out_valid, dut.busy, stall_cnt);
        end
        step();
        in_valid = 0;
        tests++;
        if (out_valid !== 1'b1 || out_instr !== i2 || dut.busy !== 32'h8) begin
            fails++; $display("FAIL flush_recap v %b instr %h busy %h exp 1 %h 8", out_valid, out_instr, dut.busy, i2);
        end
    endtask

    task automatic test_collision();
        logic [31:0] i1, i2;
        do_reset();
        i1 = enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'b0010011);
        i2 = enc_i(12'd2, 5'd0, 3'd0, 5'd7, 7'b0010011);
        in_valid = 1; in_instr = i1;
        step();
        in_instr = i2;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL waw_ready got %b exp 0", in_ready); end
        wb_valid = 1; wb_we = 0; wb_rd = 6'd7;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL coll_ready got %b exp 1", in_ready); end
        step();
        in_valid = 0;
        tests++;
        if (dut.busy !== 32'h80 || out_instr !== i2) begin
            fails++; $display("FAIL coll_set_wins busy %h instr %h exp 00000080 %h", dut.busy, out_instr, i2);
        end
        step();
        wb_valid = 0;
        tests++;
        if (dut.busy !== 32'd0) begin fails++; $display("FAIL coll_clear got %h exp 0", dut.busy); end
    endtask

    initial begin
        for (int r = 0; r < 64; r++) rf_mem[r] = 32'hA500_0000 + r;
        rf_mem[0] = 32'd0;
        rf_mem[2] = 32'd5;
        rf_mem[4] = 32'd7;
        rf_mem[5] = 32'hDEAD_0000;
        test_reset();
        test_back_to_back();
        test_raw_stall();
        test_x0();
        test_backpressure_flush();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
